// File: rtl/flash_pkg.sv
// Shared opcodes, state enumeration and address helper for the flash loader.
package flash_pkg;

    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_RELEASE_PD = 8'hAB;

    typedef enum logic [2:0] {
        RST_WAKE,
        WAKE_WAIT,
        WAKE_DLY,
        IDLE,
        ISSUE,
        WAIT_DONE,
        PRESENT
    } fl_state_e;

    // Byte address of element idx within a load; wraps modulo 2^24.
    function automatic logic [23:0] addr_at(input logic [23:0] base, input logic [15:0] idx);
        return base + {8'h00, idx};
    endfunction

endpackage

// File: rtl/flash_loader_cycle_timer.sv
// Loadable down-counter; o_expired is high once the count has reached zero.
module cycle_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/flash_loader.sv
// Reads a run of bytes from SPI flash one READ transaction at a time and
// presents them on a valid/ready stream; optionally wakes the flash after reset.
module flash_loader
    import flash_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned WAKE_DELAY     = 300,
    parameter int unsigned WAKE_EN        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_req,
    input  logic [23:0] load_addr,
    input  logic [15:0] load_len,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_err,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [15:0] out_idx,
    input  logic        out_ready,
    output logic        fl_start,
    output logic [7:0]  fl_cmd,
    output logic [23:0] fl_addr,
    output logic [7:0]  fl_data_in,
    input  logic [7:0]  fl_data_out,
    input  logic        fl_busy,
    input  logic        fl_done
);

    localparam int unsigned MAX_LOAD = (TIMEOUT_CYCLES > WAKE_DELAY) ? TIMEOUT_CYCLES : WAKE_DELAY;
    localparam int unsigned TW_RAW   = $clog2(MAX_LOAD + 1);
    localparam int unsigned TW       = (TW_RAW < 1) ? 1 : TW_RAW;
    // Timer counts N-1 down to 0 so expiry lands exactly N cycles after the load edge.
    localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] DLY_LOAD = TW'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);

    fl_state_e   r_state;
    logic [23:0] r_base;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic        r_fl_start;
    logic [7:0]  r_fl_cmd;
    logic [23:0] r_fl_addr;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [15:0] r_out_idx;
    logic        r_load_done;
    logic        r_load_err;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_expired;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TMO_LOAD;
        case (r_state)
            RST_WAKE, ISSUE: w_tmr_load = !fl_busy;
            WAKE_WAIT: begin
                w_tmr_load = fl_done;
                w_tmr_val  = DLY_LOAD;
            end
            default: w_tmr_load = 1'b0;
        endcase
    end

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_value  (w_tmr_val),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (WAKE_EN != 0) ? RST_WAKE : IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_fl_start  <= 1'b0;
            r_fl_cmd    <= '0;
            r_fl_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_fl_start  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                RST_WAKE: begin
                    if (!fl_busy) begin
                        r_fl_start <= 1'b1;
                        r_fl_cmd   <= OP_RELEASE_PD;
                        r_state    <= WAKE_WAIT;
                    end
                end
                WAKE_WAIT: begin
                    if (fl_done) begin
                        r_state <= WAKE_DLY;
                    end else if (w_expired) begin
                        r_load_err <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                WAKE_DLY: begin
                    if (w_expired) r_state <= IDLE;
                end
                IDLE: begin
                    if (load_req) begin
                        r_base <= load_addr;
                        r_len  <= load_len;
                        r_idx  <= '0;
                        if (load_len == '0) r_load_done <= 1'b1;
                        else                r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!fl_busy) begin
                        r_fl_start <= 1'b1;
                        r_fl_cmd   <= OP_READ;
                        r_fl_addr  <= addr_at(r_base, r_idx);
                        r_state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (fl_done) begin
                        r_out_data  <= fl_data_out;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end else if (w_expired) begin
                        r_load_err  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == r_len - 16'd1) begin
                            r_load_done <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 16'd1;
                            r_state <= ISSUE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_busy  = (r_state != IDLE);
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign fl_start   = r_fl_start;
    assign fl_cmd     = r_fl_cmd;
    assign fl_addr    = r_fl_addr;
    assign fl_data_in = 8'h00;

endmodule
